// File: rtl/decode.sv
// RV32I decode stage: register file, immediate/control decode, load-use stall, id_ex register.
// Optional write-through register file bypass is enabled by defining REGFILE_BYPASS_EN.
module decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [XLEN-1:0]         if_id__pc,
  input  logic [31:0]             if_id__ins,
  input  logic                    pipe_flush,
  input  logic                    mb_if__jump_taken,
  input  logic                    wb_id__we,
  input  logic [$clog2(NREG)-1:0] wb_id__rd,
  input  logic [XLEN-1:0]         wb_id__data,
  output logic                    data_hazard,
  output logic                    id_ex__valid,
  output logic [XLEN-1:0]         id_ex__pc,
  output logic [XLEN-1:0]         id_ex__rs1_data,
  output logic [XLEN-1:0]         id_ex__rs2_data,
  output logic [XLEN-1:0]         id_ex__imm,
  output logic [$clog2(NREG)-1:0] id_ex__rd,
  output logic [4:0]              id_ex__opcode,
  output logic [2:0]              id_ex__funct3,
  output logic                    id_ex__funct7b5,
  output logic                    id_ex__illegal
);
  localparam int RW = $clog2(NREG);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_MISC   = 5'b00011;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  logic [XLEN-1:0] r_rf [NREG];

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RW-1:0]   r_rd;
  logic [4:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;
  logic            r_illegal;

  logic [31:0]     w_ins;
  logic [4:0]      w_opcode;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [XLEN-1:0] w_imm;
  logic            w_known;
  logic            w_has_rd;
  logic            w_use_rs1;
  logic            w_use_rs2;
  logic            w_illegal;
  logic [RW-1:0]   w_rd;
  logic [XLEN-1:0] w_rs1_data;
  logic [XLEN-1:0] w_rs2_data;
  logic            w_dv;
  logic            w_load_hit;
  logic            w_wb_hit;
  logic            w_hz;

  assign w_ins    = if_id__ins;
  assign w_opcode = w_ins[6:2];
  assign w_rs1    = w_ins[19:15];
  assign w_rs2    = w_ins[24:20];

  always_comb begin
    w_known   = 1'b1;
    w_has_rd  = 1'b1;
    w_use_rs2 = 1'b0;
    w_imm     = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: w_imm = {w_ins[31:12], 12'b0};
      OP_JAL:  w_imm = {{12{w_ins[31]}}, w_ins[19:12], w_ins[20], w_ins[30:21], 1'b0};
      OP_JALR, OP_LOAD, OP_IMM: w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      OP_BRANCH: begin
        w_imm     = {{20{w_ins[31]}}, w_ins[7], w_ins[30:25], w_ins[11:8], 1'b0};
        w_has_rd  = 1'b0;
        w_use_rs2 = 1'b1;
      end
      OP_STORE: begin
        w_imm     = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
        w_has_rd  = 1'b0;
        w_use_rs2 = 1'b1;
      end
      OP_OP:             w_use_rs2 = 1'b1;
      OP_MISC, OP_SYSTEM: w_known  = 1'b1;
      default:           w_known   = 1'b0;
    endcase
  end

  assign w_use_rs1 = !(w_opcode == OP_LUI || w_opcode == OP_AUIPC || w_opcode == OP_JAL);
  assign w_illegal = !w_known || (w_ins[1:0] != 2'b11);
  // Illegal instructions still issue, but must never claim a destination.
  assign w_rd      = (w_has_rd && !w_illegal) ? w_ins[11:7] : '0;

  always_ff @(posedge clk) begin
    if (wb_id__we && wb_id__rd != '0) r_rf[wb_id__rd] <= wb_id__data;
  end

  always_comb begin
    w_rs1_data = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
    w_rs2_data = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
`ifdef REGFILE_BYPASS_EN
    if (wb_id__we && wb_id__rd != '0 && wb_id__rd == w_rs1) w_rs1_data = wb_id__data;
    if (wb_id__we && wb_id__rd != '0 && wb_id__rd == w_rs2) w_rs2_data = wb_id__data;
`endif
  end

  // Stall protocol: data_hazard=1 means fetch holds if_id__pc/if_id__ins and decode
  // inserts a bubble; a redirect (jump) or flush masks the stall via w_dv.
  assign w_dv       = !pipe_flush && !mb_if__jump_taken;
  assign w_load_hit = r_valid && (r_opcode == OP_LOAD) && (r_rd != '0) &&
                      ((w_use_rs1 && w_rs1 == r_rd) || (w_use_rs2 && w_rs2 == r_rd));
`ifdef REGFILE_BYPASS_EN
  assign w_wb_hit   = 1'b0;
`else
  assign w_wb_hit   = wb_id__we && (wb_id__rd != '0) &&
                      ((w_use_rs1 && w_rs1 == wb_id__rd) || (w_use_rs2 && w_rs2 == wb_id__rd));
`endif
  assign w_hz        = w_dv && (w_load_hit || w_wb_hit);
  assign data_hazard = w_hz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (mb_if__jump_taken || pipe_flush || w_hz) begin
      r_valid <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_valid    <= 1'b1;
      r_pc       <= if_id__pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= w_imm;
      r_rd       <= w_rd;
      r_opcode   <= w_opcode;
      r_funct3   <= w_ins[14:12];
      r_funct7b5 <= w_ins[30];
      r_illegal  <= w_illegal;
    end
  end

  assign id_ex__valid    = r_valid;
  assign id_ex__pc       = r_pc;
  assign id_ex__rs1_data = r_rs1_data;
  assign id_ex__rs2_data = r_rs2_data;
  assign id_ex__imm      = r_imm;
  assign id_ex__rd       = r_rd;
  assign id_ex__opcode   = r_opcode;
  assign id_ex__funct3   = r_funct3;
  assign id_ex__funct7b5 = r_funct7b5;
  assign id_ex__illegal  = r_illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: fixed vectors, hand sequences for stalls/flush/reset,
// and randomized traffic against an instruction-level reference model.
module tb_decode;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id__pc;
  logic [31:0] if_id__ins;
  logic        pipe_flush;
  logic        mb_if__jump_taken;
  logic        wb_id__we;
  logic [4:0]  wb_id__rd;
  logic [31:0] wb_id__data;
  logic        data_hazard;
  logic        id_ex__valid;
  logic [31:0] id_ex__pc;
  logic [31:0] id_ex__rs1_data;
  logic [31:0] id_ex__rs2_data;
  logic [31:0] id_ex__imm;
  logic [4:0]  id_ex__rd;
  logic [4:0]  id_ex__opcode;
  logic [2:0]  id_ex__funct3;
  logic        id_ex__funct7b5;
  logic        id_ex__illegal;

  decode dut (
    .clk(clk), .rst_n(rst_n), .if_id__pc(if_id__pc), .if_id__ins(if_id__ins),
    .pipe_flush(pipe_flush), .mb_if__jump_taken(mb_if__jump_taken),
    .wb_id__we(wb_id__we), .wb_id__rd(wb_id__rd), .wb_id__data(wb_id__data),
    .data_hazard(data_hazard), .id_ex__valid(id_ex__valid), .id_ex__pc(id_ex__pc),
    .id_ex__rs1_data(id_ex__rs1_data), .id_ex__rs2_data(id_ex__rs2_data),
    .id_ex__imm(id_ex__imm), .id_ex__rd(id_ex__rd), .id_ex__opcode(id_ex__opcode),
    .id_ex__funct3(id_ex__funct3), .id_ex__funct7b5(id_ex__funct7b5),
    .id_ex__illegal(id_ex__illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: architectural registers and what was last issued.
  logic [31:0] regs [32];
  bit          m_valid;
  bit          m_load;
  logic [4:0]  m_rd;

  logic [6:0] gen_ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                               7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                               7'b0110011, 7'b0001011, 7'b1111111};

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        ill;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_legal(logic [31:0] ins);
    return (ins[1:0] == 2'b11) && (ins[6:2] inside {5'b01101, 5'b00101, 5'b11011, 5'b11001,
           5'b11000, 5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100});
  endfunction

  function automatic logic [4:0] m_dest(logic [31:0] ins);
    if (!m_legal(ins)) return 5'd0;
    if (ins[6:2] == 5'b11000 || ins[6:2] == 5'b01000) return 5'd0;
    return ins[11:7];
  endfunction

  function automatic logic [31:0] m_imm(logic [31:0] ins);
    logic [31:0] sgn;
    sgn = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    case (ins[6:2])
      5'b00000, 5'b00100, 5'b11001: return (sgn << 12) | (ins >> 20);
      5'b01000: return (sgn << 12) | ((ins >> 25) << 5) | ((ins >> 7) & 32'd31);
      5'b11000: return (sgn << 12) | (((ins >> 7) & 32'd1) << 11) |
                       (((ins >> 25) & 32'd63) << 5) | (((ins >> 8) & 32'd15) << 1);
      5'b01101, 5'b00101: return ins & 32'hFFFF_F000;
      5'b11011: return (sgn << 20) | (((ins >> 12) & 32'd255) << 12) |
                       (((ins >> 20) & 32'd1) << 11) | (((ins >> 21) & 32'd1023) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_use1(logic [4:0] op);
    return !(op == 5'b01101 || op == 5'b00101 || op == 5'b11011);
  endfunction

  function automatic bit m_use2(logic [4:0] op);
    return (op == 5'b01100 || op == 5'b01000 || op == 5'b11000);
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] idx, bit we, logic [4:0] wrd, logic [31:0] wdata);
    if (idx == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (we && wrd == idx) return wdata;
`endif
    return regs[idx];
  endfunction

  // One decode cycle: drive, check the stall request, clock, check id_ex against the model.
  task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input bit flush,
                       input bit jump, input bit we, input logic [4:0] wrd,
                       input logic [31:0] wdata, input int exp_hz, output bit hz);
    logic [4:0]  r1, r2, e_rd;
    logic [31:0] e_imm, e_r1, e_r2;
    bit          u1, u2, dv, e_valid;
    if_id__ins = ins; if_id__pc = pc; pipe_flush = flush; mb_if__jump_taken = jump;
    wb_id__we = we; wb_id__rd = wrd; wb_id__data = wdata;
    #1;
    dv = !flush && !jump;
    r1 = ins[19:15]; r2 = ins[24:20];
    u1 = m_use1(ins[6:2]); u2 = m_use2(ins[6:2]);
    hz = dv && m_valid && m_load && (m_rd != 5'd0) && ((u1 && r1 == m_rd) || (u2 && r2 == m_rd));
`ifndef REGFILE_BYPASS_EN
    hz = hz || (dv && we && wrd != 5'd0 && ((u1 && r1 == wrd) || (u2 && r2 == wrd)));
`endif
    check("data_hazard", {31'b0, data_hazard}, {31'b0, hz});
    if (exp_hz >= 0) check("data_hazard_fixed", {31'b0, data_hazard}, exp_hz);
    e_valid = dv && !hz;
    e_rd    = e_valid ? m_dest(ins) : 5'd0;
    e_imm   = m_imm(ins);
    e_r1    = m_read(r1, we, wrd, wdata);
    e_r2    = m_read(r2, we, wrd, wdata);
    @(posedge clk);
    #1;
    check("valid", {31'b0, id_ex__valid}, {31'b0, e_valid});
    check("rd", {27'b0, id_ex__rd}, {27'b0, e_rd});
    if (e_valid) begin
      check("pc", id_ex__pc, pc);
      check("imm", id_ex__imm, e_imm);
      check("opcode", {27'b0, id_ex__opcode}, {27'b0, ins[6:2]});
      check("funct3", {29'b0, id_ex__funct3}, {29'b0, ins[14:12]});
      check("funct7b5", {31'b0, id_ex__funct7b5}, {31'b0, ins[30]});
      check("illegal", {31'b0, id_ex__illegal}, {31'b0, !m_legal(ins)});
      check("rs1_data", id_ex__rs1_data, e_r1);
      check("rs2_data", id_ex__rs2_data, e_r2);
    end
    if (we && wrd != 5'd0) regs[wrd] = wdata;
    m_valid = e_valid;
    m_load  = e_valid && (ins[6:2] == 5'b00000);
    m_rd    = e_rd;
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    w        = $urandom;
    w[6:0]   = gen_ops[$urandom_range(0, 10)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  localparam logic [31:0] ADD_X4_X3_X3 = 32'h0031_8233;
  localparam logic [31:0] ADD_X6_X5_X0 = 32'h0002_8333;
  localparam logic [31:0] ADD_X6_X0_X0 = 32'h0000_0333;
  localparam logic [31:0] LW_X5_0_X1   = 32'h0000_A283;
  localparam logic [31:0] LW_X0_0_X1   = 32'h0000_A003;
  localparam logic [31:0] ADDI_X1_5    = 32'h0050_0093;

  initial begin
    bit          hz;
    logic [31:0] r_ins, r_pc;
    bit          hold;

    vecs[0]  = '{32'h0050_0093, 32'h100, 32'h0000_0005, 5'd1, 5'b00100, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFE00_0CE3, 32'h104, 32'hFFFF_FFF8, 5'd0, 5'b11000, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{32'h0010_00EF, 32'h108, 32'h0000_0800, 5'd1, 5'b11011, 3'd0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0080_A283, 32'h10C, 32'h0000_0008, 5'd5, 5'b00000, 3'd2, 1'b0, 1'b0};
    vecs[4]  = '{32'hABCD_E137, 32'h110, 32'hABCD_E000, 5'd2, 5'b01101, 3'd6, 1'b0, 1'b0};
    vecs[5]  = '{32'hFE20_AFA3, 32'h114, 32'hFFFF_FFFF, 5'd0, 5'b01000, 3'd2, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0000, 32'h118, 32'h0000_0000, 5'd0, 5'b00000, 3'd0, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_02FF, 32'h11C, 32'h0000_0000, 5'd0, 5'b11111, 3'd0, 1'b0, 1'b1};
    vecs[8]  = '{32'h8000_0397, 32'h120, 32'h8000_0000, 5'd7, 5'b00101, 3'd0, 1'b0, 1'b0};
    vecs[9]  = '{32'hFFC1_00E7, 32'h124, 32'hFFFF_FFFC, 5'd1, 5'b11001, 3'd0, 1'b1, 1'b0};
    vecs[10] = '{32'h4020_81B3, 32'h128, 32'h0000_0000, 5'd3, 5'b01100, 3'd0, 1'b1, 1'b0};

    // Clock/reset
    rst_n = 1'b0; if_id__pc = '0; if_id__ins = '0; pipe_flush = 1'b0;
    mb_if__jump_taken = 1'b0; wb_id__we = 1'b0; wb_id__rd = '0; wb_id__data = '0;
    m_valid = 0; m_load = 0; m_rd = '0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, id_ex__valid}, 32'd0);
    check("rst_pc", id_ex__pc, 32'd0);
    check("rst_rs1", id_ex__rs1_data, 32'd0);
    check("rst_rs2", id_ex__rs2_data, 32'd0);
    check("rst_imm", id_ex__imm, 32'd0);
    check("rst_rd", {27'b0, id_ex__rd}, 32'd0);
    check("rst_opcode", {27'b0, id_ex__opcode}, 32'd0);
    check("rst_funct3", {29'b0, id_ex__funct3}, 32'd0);
    check("rst_f7b5", {31'b0, id_ex__funct7b5}, 32'd0);
    check("rst_illegal", {31'b0, id_ex__illegal}, 32'd0);
    check("rst_hazard", {31'b0, data_hazard}, 32'd0);
    rst_n = 1'b1;

    // Flush cycle, then ADDI x1,x0,5 at pc 0
    cycle(ADDI_X1_5, 32'h0, 1, 0, 0, 5'd0, 32'h0, 0, hz);
    check("flush_valid", {31'b0, id_ex__valid}, 32'd0);
    cycle(ADDI_X1_5, 32'h0, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("addi_valid", {31'b0, id_ex__valid}, 32'd1);
    check("addi_imm", id_ex__imm, 32'd5);
    check("addi_rd", {27'b0, id_ex__rd}, 32'd1);
    check("addi_pc", id_ex__pc, 32'd0);

    // Give every register a known value while decode is flushed
    for (int i = 1; i < 32; i++)
      cycle(32'h0, 32'h0, 1, 0, 1, 5'(i), 32'hA500_0000 + i * 32'h0001_0101, 0, hz);

    // Write x3, then read it back through ADD x4,x3,x3
    cycle(32'h0, 32'h0, 1, 0, 1, 5'd3, 32'h0000_1234, 0, hz);
    cycle(ADD_X4_X3_X3, 32'h200, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("wb_rs1", id_ex__rs1_data, 32'h0000_1234);
    check("wb_rs2", id_ex__rs2_data, 32'h0000_1234);
`ifdef REGFILE_BYPASS_EN
    cycle(ADD_X4_X3_X3, 32'h204, 0, 0, 1, 5'd3, 32'h0000_5678, 0, hz);
    check("byp_valid", {31'b0, id_ex__valid}, 32'd1);
    check("byp_rs1", id_ex__rs1_data, 32'h0000_5678);
    check("byp_rs2", id_ex__rs2_data, 32'h0000_5678);
`else
    cycle(ADD_X4_X3_X3, 32'h204, 0, 0, 1, 5'd3, 32'h0000_5678, 1, hz);
    check("wbhz_bubble", {31'b0, id_ex__valid}, 32'd0);
    cycle(ADD_X4_X3_X3, 32'h204, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("wbhz_valid", {31'b0, id_ex__valid}, 32'd1);
    check("wbhz_rs1", id_ex__rs1_data, 32'h0000_5678);
    check("wbhz_rs2", id_ex__rs2_data, 32'h0000_5678);
`endif

    // Load-use: one bubble, then the consumer issues
    cycle(LW_X5_0_X1, 32'h300, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    cycle(ADD_X6_X5_X0, 32'h304, 0, 0, 0, 5'd0, 32'h0, 1, hz);
    check("lu_bubble_valid", {31'b0, id_ex__valid}, 32'd0);
    check("lu_bubble_rd", {27'b0, id_ex__rd}, 32'd0);
    cycle(ADD_X6_X5_X0, 32'h304, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("lu_issue_valid", {31'b0, id_ex__valid}, 32'd1);
    check("lu_issue_rd", {27'b0, id_ex__rd}, 32'd6);
    cycle(LW_X0_0_X1, 32'h308, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    cycle(ADD_X6_X0_X0, 32'h30C, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("lu_x0_valid", {31'b0, id_ex__valid}, 32'd1);

    // Load-use masked by a redirect
    cycle(LW_X5_0_X1, 32'h400, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    cycle(ADD_X6_X5_X0, 32'h404, 0, 1, 0, 5'd0, 32'h0, 0, hz);
    check("jump_valid", {31'b0, id_ex__valid}, 32'd0);

    // x0 ignores writes and reads as zero
    cycle(32'h0, 32'h0, 1, 0, 1, 5'd0, 32'hDEAD_BEEF, 0, hz);
    cycle(ADD_X6_X0_X0, 32'h500, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    check("x0_rs1", id_ex__rs1_data, 32'h0);
    check("x0_rs2", id_ex__rs2_data, 32'h0);

    // Fixed vector table
    for (int i = 0; i < 11; i++) begin
      cycle(vecs[i].ins, vecs[i].pc, 0, 0, 0, 5'd0, 32'h0, 0, hz);
      check($sformatf("vec%0d_valid", i), {31'b0, id_ex__valid}, 32'd1);
      check($sformatf("vec%0d_imm", i), id_ex__imm, vecs[i].imm);
      check($sformatf("vec%0d_rd", i), {27'b0, id_ex__rd}, {27'b0, vecs[i].rd});
      check($sformatf("vec%0d_op", i), {27'b0, id_ex__opcode}, {27'b0, vecs[i].op});
      check($sformatf("vec%0d_f3", i), {29'b0, id_ex__funct3}, {29'b0, vecs[i].f3});
      check($sformatf("vec%0d_f7", i), {31'b0, id_ex__funct7b5}, {31'b0, vecs[i].f7});
      check($sformatf("vec%0d_ill", i), {31'b0, id_ex__illegal}, {31'b0, vecs[i].ill});
      check($sformatf("vec%0d_pc", i), id_ex__pc, vecs[i].pc);
    end

    // Asynchronous reset with a pending load-use hazard
    cycle(LW_X5_0_X1, 32'h600, 0, 0, 0, 5'd0, 32'h0, 0, hz);
    if_id__ins = ADD_X6_X5_X0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, id_ex__valid}, 32'd0);
    check("mid_rst_rd", {27'b0, id_ex__rd}, 32'd0);
    check("mid_rst_hazard", {31'b0, data_hazard}, 32'd0);
    rst_n = 1'b1;
    m_valid = 0; m_load = 0; m_rd = '0;

    // Randomized traffic; a stalled instruction is held as fetch would
    hold = 0;
    r_ins = 32'h0; r_pc = 32'h0;
    for (int n = 0; n < 600; n++) begin
      if (!hold) begin
        r_ins = gen_ins();
        r_pc  = $urandom & 32'hFFFF_FFFC;
      end
      cycle(r_ins, r_pc, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, -1, hz);
      hold = hz;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
